// File: rtl/piso_serializer_pkg.sv
// -----------------------------------------------------------------------------
// piso_serializer_pkg
//   Shared types and constants for the parallel-in / serial-out serializer.
//   Contents:
//     DEFAULT_W : default parallel word width
//     state_t   : serializer FSM state encoding (IDLE, SHIFT, PARITY)
//   PARITY is only reachable when PISO_SERIALIZER_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package piso_serializer_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage : piso_serializer_pkg

// File: rtl/piso_serializer_if.sv
// -----------------------------------------------------------------------------
// piso_serializer_if
//   Groups the upstream word handshake and the downstream serial handshake.
//   Parameter W : parallel word width.
//   Signals:
//     up_valid  upstream word is valid            (upstream -> serializer)
//     up_ready  serializer accepts a word         (serializer -> upstream)
//     up_data   parallel word, W bits             (upstream -> serializer)
//     ser_valid ser_data carries a valid bit      (serializer -> downstream)
//     ser_data  serial bit, LSB first             (serializer -> downstream)
//     ser_last  final beat of a word              (serializer -> downstream)
//     ser_ready downstream can take a beat        (downstream -> serializer)
//   Handshake rule (both sides): a transfer happens on a rising clock edge
//   where valid && ready; the sender keeps valid and payload stable until it
//   transfers, and ready may depend combinationally on the other side's signals.
//   Modports:
//     slave  : the serializer's view
//     master : the environment's view (upstream source + downstream sink)
// -----------------------------------------------------------------------------
interface piso_serializer_if
    import piso_serializer_pkg::*;
#(
    parameter int W = DEFAULT_W
);

    logic         up_valid;
    logic         up_ready;
    logic [W-1:0] up_data;
    logic         ser_valid;
    logic         ser_data;
    logic         ser_last;
    logic         ser_ready;

    modport slave (
        input  up_valid,
        input  up_data,
        input  ser_ready,
        output up_ready,
        output ser_valid,
        output ser_data,
        output ser_last
    );

    modport master (
        output up_valid,
        output up_data,
        output ser_ready,
        input  up_ready,
        input  ser_valid,
        input  ser_data,
        input  ser_last
    );

endinterface : piso_serializer_if

// File: rtl/bit_select_mux.sv
// -----------------------------------------------------------------------------
// bit_select_mux
//   W:1 bit selector built as a balanced binary tree of mux2_cell instances.
//   Parameters:
//     W  : number of data bits (>= 2)
//   Ports:
//     data : W-bit input word
//     sel  : index of the bit to select, $clog2(W) bits
//     y    : data[sel]
//   The tree is padded up to the next power of two with constant-zero leaves;
//   those leaves are never selected as long as sel <= W-1.
// -----------------------------------------------------------------------------
module bit_select_mux #(
    parameter int W = 8,
    localparam int SW = $clog2(W)
) (
    input  logic [W-1:0]  data,
    input  logic [SW-1:0] sel,
    output logic          y
);

    localparam int N = 1 << SW;

    // Heap layout: node 0 is the root, node k has children 2k+1 / 2k+2,
    // and leaf j sits at node N-1+j.
    logic [2*N-2:0] node;

    for (genvar j = 0; j < N; j++) begin : g_leaf
        if (j < W) begin : g_data
            assign node[N-1+j] = data[j];
        end else begin : g_pad
            assign node[N-1+j] = 1'b0;
        end
    end

    // A node at depth d steers on select bit SW-1-d, so the root uses the MSB
    // and the last level of muxes uses the LSB.
    for (genvar k = 0; k < N - 1; k++) begin : g_node
        localparam int DEPTH = $clog2(k + 2) - 1;
        mux2_cell u_mux (
            .a (node[2*k+1]),
            .b (node[2*k+2]),
            .s (sel[SW-1-DEPTH]),
            .y (node[k])
        );
    end

    assign y = node[0];

endmodule : bit_select_mux

// File: rtl/mux2_cell.sv
// -----------------------------------------------------------------------------
// mux2_cell
//   Basic 2:1 multiplexer cell.
//   Ports:
//     a : selected when s == 0
//     b : selected when s == 1
//     s : select
//     y : output
// -----------------------------------------------------------------------------
module mux2_cell (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule : mux2_cell

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out serializer. A W-bit word is accepted on the
//   upstream handshake and emitted LSB first, one bit per downstream beat.
//   Bit 0 appears the cycle after acceptance; a new word can be accepted on
//   the final beat so back-to-back words stream with no bubble.
//
//   Optional feature: define PISO_SERIALIZER_PARITY_EN to append one even
//   parity beat (XOR of all word bits) after the data bits; ser_last then
//   marks the parity beat instead of bit W-1.
//
//   Parameters:
//     W         : parallel word width (>= 2)
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset
//     bus       : piso_serializer_if.slave (up_* and ser_* handshakes)
//     dbg_state : current FSM state
//     dbg_cnt   : current bit index
// -----------------------------------------------------------------------------
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int W = DEFAULT_W,
    localparam int CW = $clog2(W)
) (
    input  logic              clk,
    input  logic              rst_n,
    piso_serializer_if.slave  bus,
    output state_t            dbg_state,
    output logic [CW-1:0]     dbg_cnt
);

    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [W-1:0]  word_q,  word_d;

    logic          mux_bit;
    logic          final_beat;
    logic          accept;
    logic          up_ready;
    logic          ser_valid;
    logic          ser_data;
    logic          ser_last;

    bit_select_mux #(
        .W (W)
    ) u_bit_select_mux (
        .data (word_q),
        .sel  (cnt_q),
        .y    (mux_bit)
    );

    // ------------------------------------------------------------------
    // Output decode. final_beat flags the beat after which the block is
    // free to take a new word; up_ready opens on that beat only once the
    // beat is actually transferring.
    // ------------------------------------------------------------------
    always_comb begin
        ser_valid  = 1'b0;
        ser_data   = 1'b0;
        ser_last   = 1'b0;
        final_beat = 1'b0;
        case (state_q)
            SHIFT: begin
                ser_valid = 1'b1;
                ser_data  = mux_bit;
`ifndef PISO_SERIALIZER_PARITY_EN
                ser_last   = (cnt_q == LAST_IDX);
                final_beat = (cnt_q == LAST_IDX);
`endif
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            PARITY: begin
                ser_valid  = 1'b1;
                ser_data   = ^word_q;
                ser_last   = 1'b1;
                final_beat = 1'b1;
            end
`endif
            default: begin
            end
        endcase
        // Gated by rst_n so upstream never sees a ready while in reset.
        up_ready = rst_n && ((state_q == IDLE) || (final_beat && bus.ser_ready));
        accept   = bus.up_valid && up_ready;
    end

    // ------------------------------------------------------------------
    // Next-state logic. An accept always wins: it can only happen in IDLE
    // or on a transferring final beat, so it also covers the no-bubble
    // reload path.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        if (accept) begin
            word_d  = bus.up_data;
            cnt_d   = '0;
            state_d = SHIFT;
        end else begin
            case (state_q)
                SHIFT: begin
                    if (bus.ser_ready) begin
                        if (cnt_q != LAST_IDX) begin
                            cnt_d = cnt_q + 1'b1;
                        end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = IDLE;
`endif
                        end
                    end
                end
`ifdef PISO_SERIALIZER_PARITY_EN
                PARITY: begin
                    if (bus.ser_ready) begin
                        state_d = IDLE;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    assign bus.up_ready  = up_ready;
    assign bus.ser_valid = ser_valid;
    assign bus.ser_data  = ser_data;
    assign bus.ser_last  = ser_last;

    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Directed bench for piso_serializer (W = 8). Expected serial beats are
//   queued when a word is issued; a monitor pops and compares on every
//   ser_valid && ser_ready seen at the falling edge.
// -----------------------------------------------------------------------------
module tb_piso_serializer;
    import piso_serializer_pkg::*;

    localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int NB     = W + 1;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int NB     = W;
`endif

    logic         clk;
    logic         rst_n;
    state_t       dbg_state;
    logic [2:0]   dbg_cnt;

    piso_serializer_if #(.W(W)) bus ();

    piso_serializer #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_cnt   (dbg_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [1:0] exp_q[$];   // {last, data}
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Hand-computed parity is passed in with each vector.
    task automatic push_expected(input logic [7:0] d, input logic par);
        for (int i = 0; i < W; i++) begin
            exp_q.push_back({(!PAR_EN && (i == W - 1)), d[i]});
        end
        if (PAR_EN) begin
            exp_q.push_back({1'b1, par});
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] e;
        if (rst_n && bus.ser_valid && bus.ser_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data=%0b last=%0b, required no beat (t=%0t)",
                         bus.ser_data, bus.ser_last, $time);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", bus.ser_data, e[0]);
                chk("beat_last", bus.ser_last, e[1]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [7:0] d, input logic par);
        int n = 0;
        push_expected(d, par);
        bus.up_valid = 1'b1;
        bus.up_data  = d;
        @(negedge clk);
        while (!bus.up_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_seen", bus.up_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.up_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        @(negedge clk);
        while (!(bus.ser_valid && dbg_cnt == 3'(target)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_cnt", {29'd0, dbg_cnt}, target);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && dbg_state == IDLE) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", dbg_state, IDLE);
        chk("queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Sends one word and checks beat timing: contiguous valid from the cycle
    // after acceptance, bit 0 first, ser_last only on the final beat.
    task automatic run_word_checked(input logic [7:0] d, input logic par);
        send_word(d, par);
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            chk("word_valid", bus.ser_valid, 1'b1);
            chk("word_last", bus.ser_last, (i == NB - 1));
            if (i == 0) chk("first_cnt", {29'd0, dbg_cnt}, 0);
        end
        @(negedge clk);
        chk("after_word_valid", bus.ser_valid, 1'b0);
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs[3];

    initial begin
        vecs[0] = '{data: 8'h07, par: 1'b1};
        vecs[1] = '{data: 8'hFF, par: 1'b0};
        vecs[2] = '{data: 8'h3C, par: 1'b0};

        rst_n         = 1'b0;
        bus.up_valid  = 1'b0;
        bus.up_data   = '0;
        bus.ser_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_up_ready", bus.up_ready, 1'b0);
        chk("rst_ser_valid", bus.ser_valid, 1'b0);
        chk("rst_ser_data", bus.ser_data, 1'b0);
        chk("rst_ser_last", bus.ser_last, 1'b0);
        chk("rst_state", dbg_state, IDLE);
        chk("rst_cnt", {29'd0, dbg_cnt}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_up_ready", bus.up_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single word A5: 1,0,1,0,0,1,0,1
        run_word_checked(8'hA5, 1'b0);

        // Back-to-back A5 then 3C: no gap, up_ready only on each final beat
        fork
            begin
                send_word(8'hA5, 1'b0);
                send_word(8'h3C, 1'b0);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!bus.ser_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 2 * NB; i++) begin
                    chk("b2b_valid", bus.ser_valid, 1'b1);
                    chk("b2b_up_ready", bus.up_ready, (i == NB - 1) || (i == 2 * NB - 1));
                    if (i < 2 * NB - 1) @(negedge clk);
                end
            end
        join
        wait_idle();

        // Backpressure on bit 3 of A5 for 3 cycles
        send_word(8'hA5, 1'b0);
        wait_cnt(2);
        @(posedge clk);
        #1;
        bus.ser_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_data", bus.ser_data, 1'b0);
            chk("stall_cnt", {29'd0, dbg_cnt}, 3);
            chk("stall_valid", bus.ser_valid, 1'b1);
            chk("stall_state", dbg_state, SHIFT);
        end
        @(posedge clk);
        #1;
        bus.ser_ready = 1'b1;
        @(negedge clk);
        chk("resume_cnt", {29'd0, dbg_cnt}, 3);
        chk("resume_data", bus.ser_data, 1'b0);
        wait_idle();

        // up_data churn while shifting: must not be accepted
        send_word(8'hA5, 1'b0);
        bus.up_valid = 1'b1;
        bus.up_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busy_up_ready", bus.up_ready, 1'b0);
            @(posedge clk);
            #1;
            bus.up_data = bus.up_data ^ 8'h5A;
        end
        bus.up_valid = 1'b0;
        wait_idle();

        // Reset in the middle of bit 4
        send_word(8'hA5, 1'b0);
        wait_cnt(4);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", bus.ser_valid, 1'b0);
        chk("mid_rst_data", bus.ser_data, 1'b0);
        chk("mid_rst_last", bus.ser_last, 1'b0);
        chk("mid_rst_up_ready", bus.up_ready, 1'b0);
        chk("mid_rst_state", dbg_state, IDLE);
        chk("mid_rst_cnt", {29'd0, dbg_cnt}, 0);
        @(negedge clk);
        chk("mid_rst_hold_valid", bus.ser_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_word(8'h01, 1'b1);
        @(negedge clk);
        chk("post_rst_bit0", bus.ser_data, 1'b1);
        chk("post_rst_cnt", {29'd0, dbg_cnt}, 0);
        wait_idle();

        // Remaining directed vectors (07 exercises the parity beat = 1)
        foreach (vecs[i]) begin
            run_word_checked(vecs[i].data, vecs[i].par);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, required completion before %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_piso_serializer
